seguidor_trayectoria: RTL and testbench

- Consumer and playback end of the coordinate-memory controller: it pulls stored (x,y) points one at a time with a `dato_siguiente`-style request.
- It drives the cutter head from its current position to each point as step/direction pulses.
- It honours pause and cancel, and detects end of path.
- It sits between the memory controller's `x_salida`/`y_salida`/`cortando` outputs and the axis actuator drivers.

---
 rtl/seguidor_trayectoria_pkg.sv | 20 ++
 rtl/seguidor_trayectoria_if.sv | 34 +++
 rtl/seguidor_trayectoria_generador_paso.sv | 30 +++
 rtl/seguidor_trayectoria.sv | 144 ++++++++++++++
 tb/tb_seguidor_trayectoria.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seguidor_trayectoria_pkg.sv
// Shared definitions for the path follower: state encoding and default coordinate width.
package seguidor_trayectoria_pkg;

    localparam int ANCHO_DEF = 6;

    typedef enum logic [2:0] {
        REPOSO  = 3'd0,
        PEDIR   = 3'd1,
        ESPERAR = 3'd2,
        MOVER   = 3'd3,
        PAUSA   = 3'd4,
        FIN     = 3'd5
    } estado_t;

    // A path is in progress in every state except idle and finished.
    function automatic logic activo(estado_t e);
        return (e != REPOSO) && (e != FIN);
    endfunction

endpackage

// File: rtl/seguidor_trayectoria_if.sv
// Bus between the coordinate-memory controller side and the path follower.
// master: memory controller / actuator side. slave: the follower itself.
interface seguidor_trayectoria_if #(
    parameter int ANCHO = seguidor_trayectoria_pkg::ANCHO_DEF
);
    logic             habilitar;
    logic             pausar;
    logic             cancelar;
    logic             fin_datos;
    logic [ANCHO-1:0] x_entrada;
    logic [ANCHO-1:0] y_entrada;
    logic             pedir_dato;
    logic             paso_x;
    logic             dir_x;
    logic             paso_y;
    logic             dir_y;
    logic [ANCHO-1:0] x_actual;
    logic [ANCHO-1:0] y_actual;
    logic             ocupado;
    logic             terminado;
    logic [2:0]       estado_actual;

    modport master (
        output habilitar, pausar, cancelar, fin_datos, x_entrada, y_entrada,
        input  pedir_dato, paso_x, dir_x, paso_y, dir_y, x_actual, y_actual,
               ocupado, terminado, estado_actual
    );

    modport slave (
        input  habilitar, pausar, cancelar, fin_datos, x_entrada, y_entrada,
        output pedir_dato, paso_x, dir_x, paso_y, dir_y, x_actual, y_actual,
               ocupado, terminado, estado_actual
    );
endinterface

// File: rtl/seguidor_trayectoria_generador_paso.sv
// Step-period divider: counts 0..DIV_PASO-1 and flags the terminal count.
// i_congelar holds the count (pause), i_limpiar restarts it at 0 for a new move.
module generador_paso #(
    parameter int DIV_PASO = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_limpiar,
    input  logic i_congelar,
    output logic o_tick
);
    localparam int               W_DIV = $clog2(DIV_PASO);
    localparam logic [W_DIV-1:0] TC    = W_DIV'(DIV_PASO - 1);
    localparam logic [W_DIV-1:0] UNO   = W_DIV'(1);

    logic [W_DIV-1:0] r_cuenta;

    // Divider count with clear priority over freeze
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cuenta <= '0;
        end else if (i_limpiar) begin
            r_cuenta <= '0;
        end else if (!i_congelar) begin
            r_cuenta <= (r_cuenta == TC) ? '0 : r_cuenta + UNO;
        end
    end

    assign o_tick = (r_cuenta == TC);
endmodule

// File: rtl/seguidor_trayectoria.sv
// Path follower: fetches (x,y) points from the coordinate memory and walks the
// cutter head to each one with step/direction pulses.
// Build option: DIAGONAL_EN -- when defined both axes may step in the same
// period (Chebyshev motion); otherwise x is completed before y.
//
// state   | meaning
// REPOSO  | idle, waiting for habilitar
// PEDIR   | one-cycle request for the next point
// ESPERAR | waiting out the memory latency, then latch point / end flag
// MOVER   | stepping toward the target, one period per DIV_PASO cycles
// PAUSA   | stepping frozen while pausar is high
// FIN     | path complete, held until habilitar drops
module seguidor_trayectoria
    import seguidor_trayectoria_pkg::*;
#(
    parameter int ANCHO         = ANCHO_DEF,
    parameter int DIV_PASO      = 4,
    parameter int LATENCIA_DATO = 2
) (
    input logic                   clock,
    input logic                   reset_n,
    seguidor_trayectoria_if.slave bus
);
    localparam int               W_LAT     = (LATENCIA_DATO > 1) ? $clog2(LATENCIA_DATO) : 1;
    localparam logic [W_LAT-1:0] LAT_CARGA = W_LAT'(LATENCIA_DATO - 1);
    localparam logic [W_LAT-1:0] LAT_UNO   = W_LAT'(1);
    localparam logic [ANCHO-1:0] UNO       = ANCHO'(1);

    estado_t          r_estado;
    estado_t          w_siguiente;
    logic [ANCHO-1:0] r_x, r_y, r_tx, r_ty;
    logic [W_LAT-1:0] r_lat;
    logic             r_paso_x, r_paso_y, r_dir_x, r_dir_y;
    logic             w_tick, w_abortar, w_en_destino, w_latch, w_paso_ok;
    logic             w_mueve_x, w_mueve_y, w_sube_x, w_sube_y;

    assign w_abortar    = bus.cancelar | ~bus.habilitar;
    assign w_en_destino = (r_x == r_tx) && (r_y == r_ty);
    assign w_latch      = (r_estado == ESPERAR) && (r_lat == '0) && !w_abortar;
    assign w_paso_ok    = (r_estado == MOVER) && w_tick && !w_abortar;
    assign w_sube_x     = (r_tx > r_x);
    assign w_sube_y     = (r_ty > r_y);

`ifdef DIAGONAL_EN
    assign w_mueve_x = w_paso_ok && (r_x != r_tx);
    assign w_mueve_y = w_paso_ok && (r_y != r_ty);
`else
    assign w_mueve_x = w_paso_ok && (r_x != r_tx);
    assign w_mueve_y = w_paso_ok && (r_x == r_tx) && (r_y != r_ty);
`endif

    generador_paso #(.DIV_PASO(DIV_PASO)) u_generador_paso (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_limpiar  (w_latch && !bus.fin_datos),
        .i_congelar (r_estado != MOVER),
        .o_tick     (w_tick)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_estado <= REPOSO;
        else          r_estado <= w_siguiente;
    end

    // Next-state decode; abort wins over arrival, arrival over pause
    always_comb begin
        w_siguiente = r_estado;
        case (r_estado)
            REPOSO:  if (bus.habilitar && !bus.cancelar) w_siguiente = PEDIR;
            PEDIR:   w_siguiente = w_abortar ? REPOSO : ESPERAR;
            ESPERAR: begin
                if (w_abortar)          w_siguiente = REPOSO;
                else if (r_lat == '0)   w_siguiente = bus.fin_datos ? FIN : MOVER;
            end
            MOVER: begin
                if (w_abortar)          w_siguiente = REPOSO;
                else if (w_en_destino)  w_siguiente = PEDIR;
                else if (bus.pausar)    w_siguiente = PAUSA;
            end
            PAUSA: begin
                if (w_abortar)          w_siguiente = REPOSO;
                else if (!bus.pausar)   w_siguiente = MOVER;
            end
            FIN:     if (!bus.habilitar) w_siguiente = REPOSO;
            default: w_siguiente = REPOSO;
        endcase
    end

    // Memory latency down-counter, loaded while the request is out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                r_lat <= '0;
        else if (r_estado == PEDIR)                  r_lat <= LAT_CARGA;
        else if (r_estado == ESPERAR && r_lat != '0) r_lat <= r_lat - LAT_UNO;
    end

    // Targets: latched with the point, dropped on abort, untouched when the end flag comes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx <= '0;
            r_ty <= '0;
        end else if (activo(r_estado) && w_abortar) begin
            r_tx <= '0;
            r_ty <= '0;
        end else if (w_latch && !bus.fin_datos) begin
            r_tx <= bus.x_entrada;
            r_ty <= bus.y_entrada;
        end
    end

    // Step pulses with position and direction updated on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_paso_x <= 1'b0;
            r_paso_y <= 1'b0;
            r_dir_x  <= 1'b0;
            r_dir_y  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            r_paso_x <= w_mueve_x;
            r_paso_y <= w_mueve_y;
            if (w_mueve_x) begin
                r_dir_x <= w_sube_x;
                r_x     <= w_sube_x ? r_x + UNO : r_x - UNO;
            end
            if (w_mueve_y) begin
                r_dir_y <= w_sube_y;
                r_y     <= w_sube_y ? r_y + UNO : r_y - UNO;
            end
        end
    end

    assign bus.pedir_dato    = (r_estado == PEDIR);
    assign bus.paso_x        = r_paso_x;
    assign bus.dir_x         = r_dir_x;
    assign bus.paso_y        = r_paso_y;
    assign bus.dir_y         = r_dir_y;
    assign bus.x_actual      = r_x;
    assign bus.y_actual      = r_y;
    assign bus.ocupado       = activo(r_estado);
    assign bus.terminado     = (r_estado == FIN);
    assign bus.estado_actual = r_estado;
endmodule

// File: tb/tb_seguidor_trayectoria.sv
// Bench for seguidor_trayectoria: a memory model answers each request after the
// fetch latency (garbage on the bus otherwise), and a schedule model predicts
// every step pulse and request cycle from the point list.
module tb_seguidor_trayectoria;
    localparam int ANCHO = 6;
    localparam int DIV   = 4;
    localparam int LAT   = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    seguidor_trayectoria_if #(.ANCHO(ANCHO)) bus();

    seguidor_trayectoria #(.ANCHO(ANCHO), .DIV_PASO(DIV), .LATENCIA_DATO(LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int   ciclo;
        logic px, py, dx, dy;
        int   x, y;
    } evento_t;

    int      ciclo = 0;
    evento_t obs_ev[$], exp_ev[$];
    int      obs_pd[$], exp_pd[$];
    int      pt_x[$], pt_y[$];
    bit      pt_fin[$];
    int      mem_x[$], mem_y[$];
    bit      mem_fin[$];
    int      mem_cnt = -1;
    int      n_chk = 0, n_fail = 0;
    int      mx = 0, my = 0;
    logic    mdx = 1'b0, mdy = 1'b0;
    int      fin_esp;

    always @(posedge clock) ciclo <= ciclo + 1;

    task automatic chequear(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_chk++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: obtenido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    function automatic logic [63:0] emp(evento_t e);
        return {12'd0, e.ciclo, e.px, e.py, e.dx, e.dy, 8'(e.x), 8'(e.y)};
    endfunction

    function automatic int limitar(int v);
        return (v < 0) ? 0 : ((v > 63) ? 63 : v);
    endfunction

    function automatic int desplazar(int t, int pi, int pl);
        return (pl > 0 && t > pi) ? t + pl : t;
    endfunction

    // Pulse and request monitor
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.paso_x || bus.paso_y)
                obs_ev.push_back('{ciclo, bus.paso_x, bus.paso_y, bus.dir_x, bus.dir_y,
                                   int'(bus.x_actual), int'(bus.y_actual)});
            if (bus.pedir_dato) obs_pd.push_back(ciclo);
        end
    end

    // Memory model: valid point exactly LAT cycles after the request, garbage otherwise
    initial begin
        bus.x_entrada = '0;
        bus.y_entrada = '0;
        bus.fin_datos = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset_n) mem_cnt = -1;
            if (mem_cnt == 0) begin
                if (mem_x.size() > 0) begin
                    bus.x_entrada = ANCHO'(mem_x.pop_front());
                    bus.y_entrada = ANCHO'(mem_y.pop_front());
                    bus.fin_datos = mem_fin.pop_front();
                end else begin
                    bus.x_entrada = ANCHO'($urandom);
                    bus.y_entrada = ANCHO'($urandom);
                    bus.fin_datos = 1'b1;
                end
            end else begin
                bus.x_entrada = ANCHO'($urandom);
                bus.y_entrada = ANCHO'($urandom);
                bus.fin_datos = 1'($urandom);
            end
            if (mem_cnt >= 0) mem_cnt--;
            if (bus.pedir_dato) mem_cnt = LAT - 1;
        end
    end

    // Schedule model: a point fetched with request at p starts moving at p+LAT+1,
    // its k-th step period shows a pulse DIV*(k+1) cycles later, and the next
    // request follows the last pulse by one cycle. Pause shifts everything after it.
    task automatic modelar(input int s, input int pi, input int pl);
        int p;
        p = s + 1;
        exp_ev.delete();
        exp_pd.delete();
        fin_esp = -1;
        for (int i = 0; i < pt_x.size(); i++) begin
            int ax, ay, n, sgx, sgy;
            exp_pd.push_back(desplazar(p, pi, pl));
            if (pt_fin[i]) begin
                fin_esp = desplazar(p + LAT + 1, pi, pl);
                break;
            end
            ax  = (pt_x[i] > mx) ? pt_x[i] - mx : mx - pt_x[i];
            ay  = (pt_y[i] > my) ? pt_y[i] - my : my - pt_y[i];
            sgx = (pt_x[i] > mx) ? 1 : -1;
            sgy = (pt_y[i] > my) ? 1 : -1;
`ifdef DIAGONAL_EN
            n = (ax > ay) ? ax : ay;
`else
            n = ax + ay;
`endif
            for (int k = 0; k < n; k++) begin
                logic sx, sy;
`ifdef DIAGONAL_EN
                sx = (k < ax);
                sy = (k < ay);
`else
                sx = (k < ax);
                sy = (k >= ax);
`endif
                if (sx) begin mx += sgx; mdx = (sgx > 0); end
                if (sy) begin my += sgy; mdy = (sgy > 0); end
                exp_ev.push_back('{desplazar(p + LAT + 1 + DIV * (k + 1), pi, pl),
                                   sx, sy, mdx, mdy, mx, my});
            end
            p = (n > 0) ? p + LAT + 1 + DIV * n + 1 : p + LAT + 2;
        end
    endtask

    task automatic comparar(input string nombre);
        chequear({nombre, "_n_pasos"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++)
            chequear({nombre, "_paso"}, emp(obs_ev[i]), emp(exp_ev[i]));
        chequear({nombre, "_n_pedir"}, obs_pd.size(), exp_pd.size());
        for (int i = 0; i < exp_pd.size() && i < obs_pd.size(); i++)
            chequear({nombre, "_pedir"}, obs_pd[i], exp_pd[i]);
        chequear({nombre, "_pos"}, {bus.x_actual, bus.y_actual}, {ANCHO'(mx), ANCHO'(my)});
    endtask

    // Run one path that ends with an end-of-data point; optional pause at s+pi for pl cycles
    task automatic correr(input int pi, input int pl, input string nombre);
        int s, visto_fin;
        obs_ev.delete();
        obs_pd.delete();
        mem_x = pt_x; mem_y = pt_y; mem_fin = pt_fin;
        @(posedge clock); #1;
        s = ciclo;
        modelar(s, s + pi, pl);
        bus.habilitar = 1'b1;
        visto_fin = -1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            if (pl > 0) begin
                if (ciclo == s + pi)      bus.pausar = 1'b1;
                if (ciclo == s + pi + pl) bus.pausar = 1'b0;
            end
            if (bus.terminado) begin
                visto_fin = ciclo;
                break;
            end
        end
        bus.pausar = 1'b0;
        chequear({nombre, "_fin_ciclo"}, visto_fin, fin_esp);
        repeat (3) begin
            @(posedge clock); #1;
            chequear({nombre, "_fin_est"}, {bus.terminado, bus.ocupado}, 2'b10);
        end
        bus.habilitar = 1'b0;
        @(posedge clock); #1;
        chequear({nombre, "_reposo"}, bus.estado_actual, 0);
        comparar(nombre);
    endtask

    function automatic logic [21:0] salidas();
        return {bus.pedir_dato, bus.paso_x, bus.dir_x, bus.paso_y, bus.dir_y,
                bus.x_actual, bus.y_actual, bus.ocupado, bus.terminado, bus.estado_actual};
    endfunction

    initial begin
        int cx, cy, s, sv_x, sv_y;
        logic sv_dx, sv_dy;
        evento_t keep[$];

        bus.habilitar = 1'b0;
        bus.pausar    = 1'b0;
        bus.cancelar  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chequear("reset_salidas", salidas(), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // (3,2) from origin
        pt_x = '{3, 0}; pt_y = '{2, 0}; pt_fin = '{0, 1};
        correr(0, 0, "t1");

        // out to (5,5) and back to origin: decrements must stop at 0
        pt_x = '{5, 0, 0}; pt_y = '{5, 0, 0}; pt_fin = '{0, 0, 1};
        correr(0, 0, "t3");

        // 4-step move, pause 20 cycles starting in the 2nd pulse cycle
        pt_x = '{4, 0}; pt_y = '{0, 0}; pt_fin = '{0, 1};
        correr(1 + LAT + 1 + 2 * DIV, 20, "pausa");

        // random short paths, some zero-distance points
        for (int r = 0; r < 6; r++) begin
            cx = mx;
            cy = my;
            pt_x.delete(); pt_y.delete(); pt_fin.delete();
            repeat ($urandom_range(1, 4)) begin
                if ($urandom_range(0, 4) != 0) begin
                    cx = limitar(cx + int'($urandom_range(0, 12)) - 6);
                    cy = limitar(cy + int'($urandom_range(0, 12)) - 6);
                end
                pt_x.push_back(cx); pt_y.push_back(cy); pt_fin.push_back(1'b0);
            end
            pt_x.push_back(0); pt_y.push_back(0); pt_fin.push_back(1'b1);
            correr(0, 0, "aleat");
        end

        // cancel in the terminal-count cycle of the 2nd step
        pt_x.delete(); pt_y.delete(); pt_fin.delete();
        pt_x.push_back((mx < 32) ? mx + 10 : mx - 10); pt_y.push_back(my); pt_fin.push_back(1'b0);
        obs_ev.delete(); obs_pd.delete();
        mem_x = pt_x; mem_y = pt_y; mem_fin = pt_fin;
        @(posedge clock); #1;
        s = ciclo;
        sv_x = mx; sv_y = my; sv_dx = mdx; sv_dy = mdy;
        modelar(s, 0, 0);
        bus.habilitar = 1'b1;
        for (int c = 0; c < 100 && ciclo != s + LAT + 1 + 2 * DIV; c++) begin
            @(posedge clock); #1;
        end
        bus.cancelar = 1'b1;
        @(posedge clock); #1;
        bus.cancelar  = 1'b0;
        bus.habilitar = 1'b0;
        chequear("cancel_estado", bus.estado_actual, 0);
        repeat (12) @(posedge clock);
        #1;
        keep.delete();
        foreach (exp_ev[i]) if (exp_ev[i].ciclo <= s + LAT + 1 + 2 * DIV) keep.push_back(exp_ev[i]);
        exp_ev = keep;
        mx = sv_x; my = sv_y; mdx = sv_dx; mdy = sv_dy;
        if (exp_ev.size() > 0) begin
            mx  = exp_ev[exp_ev.size() - 1].x;
            my  = exp_ev[exp_ev.size() - 1].y;
            mdx = exp_ev[exp_ev.size() - 1].dx;
            mdy = exp_ev[exp_ev.size() - 1].dy;
        end
        comparar("cancel");

        // asynchronous reset in the middle of a move
        pt_x.delete(); pt_y.delete(); pt_fin.delete();
        pt_x.push_back((mx < 32) ? mx + 10 : mx - 10); pt_y.push_back(my); pt_fin.push_back(1'b0);
        mem_x = pt_x; mem_y = pt_y; mem_fin = pt_fin;
        @(posedge clock); #1;
        s = ciclo;
        bus.habilitar = 1'b1;
        for (int c = 0; c < 100 && ciclo != s + 14; c++) begin
            @(posedge clock); #1;
        end
        #2 reset_n = 1'b0;
        #1;
        chequear("reset_async", salidas(), 0);
        bus.habilitar = 1'b0;
        mem_x.delete(); mem_y.delete(); mem_fin.delete();
        @(negedge clock);
        reset_n = 1'b1;
        mx = 0; my = 0; mdx = 1'b0; mdy = 1'b0;

        // end of data on the 3rd fetch
        pt_x = '{2, 2, 0}; pt_y = '{1, 1, 0}; pt_fin = '{0, 0, 1};
        correr(0, 0, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
